sim_to_pipe: RTL and testbench

Streams simulation state back to the host over the block-throttled pipe-out endpoint. It mirrors the pipe-in waveform feeder in the opposite direction. On every rising edge of sim_clk it snapshots NCH 32-bit IEEE-754 channels (e.g. muscle length, Ia rate, force), splits each into two 16-bit words and queues them in a FIFO. The host drains the FIFO in fixed-size blocks. The block sits between the simulation core and an okBTPipeOut endpoint, and lives entirely in the ti_clk domain.

---
 rtl/sim_to_pipe_if.sv | 25 ++
 rtl/sim_to_pipe.sv | 191 +++++++++++++++++++
 tb/tb_sim_to_pipe.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sim_to_pipe_if.sv
// Pipe-out endpoint bundle between sim_to_pipe (slave) and the okBTPipeOut side (master).
// block_cnt exposes the number of ep_blockstrobe pulses seen since the last flush.
interface sim_to_pipe_if;
    logic        ep_read;
    logic        ep_blockstrobe;
    logic [15:0] ep_datain;
    logic        ep_ready;
    logic [15:0] block_cnt;

    modport master (
        output ep_read,
        output ep_blockstrobe,
        input  ep_datain,
        input  ep_ready,
        input  block_cnt
    );

    modport slave (
        input  ep_read,
        input  ep_blockstrobe,
        output ep_datain,
        output ep_ready,
        output block_cnt
    );
endinterface

// File: rtl/sim_to_pipe.sv
// Snapshots NCH float channels on each sim_clk rise, splits them into 16-bit words and
// queues them in a circular FIFO drained by the block-throttled pipe-out endpoint.
module sim_to_pipe #(
    parameter int NCH         = 4,
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  ti_clk,
    input  logic                  reset_global,
    input  logic                  reset_sim,
    input  logic                  sim_clk,
    input  logic                  enable,
    input  logic [32*NCH-1:0]     ch_data,
    sim_to_pipe_if.slave          ep,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic [15:0]           overflow_cnt,
    output logic                  underflow
);

    localparam int DEPTH       = 1 << DEPTH_LOG2;
    localparam int FRAME_WORDS = 2 * NCH;
    localparam int IDX_W       = $clog2(FRAME_WORDS);

    localparam logic [DEPTH_LOG2:0] FILL_LIMIT  = (DEPTH_LOG2+1)'(DEPTH - FRAME_WORDS);
    localparam logic [DEPTH_LOG2:0] BLOCK_LEVEL = (DEPTH_LOG2+1)'(BLOCK_WORDS);
    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(FRAME_WORDS - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    logic [2:0]                     sync_q, sync_d;
    logic                           started_q, started_d;
    logic                           armed_q, armed_d;
    logic [0:0]                     state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [32*NCH-1:0]              shadow_q, shadow_d;
    logic [DEPTH_LOG2-1:0]          wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]          rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]            fill_q, fill_d;
    logic [15:0]                    ovf_q, ovf_d;
    logic                           underflow_q, underflow_d;
    logic [15:0]                    datain_q, datain_d;
    logic                           ready_q, ready_d;
    logic [15:0]                    blk_cnt_q, blk_cnt_d;

    logic [15:0]                    mem [DEPTH];
    logic [FRAME_WORDS-1:0][15:0]   shadow_words;
    logic                           rise;
    logic                           push;
    logic                           pop;
    logic                           drop;

    assign shadow_words = shadow_q;

    // A rise only counts once s1 has been seen low after reset, so releasing reset
    // while sim_clk is already high cannot fake an edge.
    always_comb begin
        sync_d    = {sync_q[1:0], sim_clk};
        started_d = 1'b1;
        armed_d   = armed_q | (started_q & ~sync_q[0]);
        rise      = sync_q[1] & ~sync_q[2] & armed_q;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        ovf_d       = ovf_q;
        underflow_d = underflow_q;
        datain_d    = datain_q;
        blk_cnt_d   = blk_cnt_q;
        push        = 1'b0;
        pop         = 1'b0;
        drop        = 1'b0;

        if (reset_sim) begin
            state_d     = S_IDLE;
            idx_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fill_d      = '0;
            ovf_d       = '0;
            underflow_d = 1'b0;
            blk_cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise && enable) begin
                        if (fill_q <= FILL_LIMIT) begin
                            shadow_d = ch_data;
                            idx_d    = '0;
                            state_d  = S_WRITE;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
                default: begin
                    push  = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end
                    drop = rise & enable;
                end
            endcase

            if (drop && (ovf_q != 16'hFFFF)) begin
                ovf_d = ovf_q + 16'd1;
            end

            if (ep.ep_read) begin
                if (fill_q != '0) begin
                    pop      = 1'b1;
                    datain_d = mem[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end else begin
                    datain_d    = 16'h0000;
                    underflow_d = 1'b1;
                end
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end

            case ({push, pop})
                2'b10:   fill_d = fill_q + 1'b1;
                2'b01:   fill_d = fill_q - 1'b1;
                default: fill_d = fill_q;
            endcase

            if (ep.ep_blockstrobe) begin
                blk_cnt_d = blk_cnt_q + 16'd1;
            end
        end

        ready_d = (fill_d >= BLOCK_LEVEL);
    end

    always_ff @(posedge ti_clk or posedge reset_global) begin
        if (reset_global) begin
            sync_q      <= '0;
            started_q   <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            ovf_q       <= '0;
            underflow_q <= 1'b0;
            datain_q    <= '0;
            ready_q     <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            sync_q      <= sync_d;
            started_q   <= started_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            ovf_q       <= ovf_d;
            underflow_q <= underflow_d;
            datain_q    <= datain_d;
            ready_q     <= ready_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    always_ff @(posedge ti_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= shadow_words[idx_q];
        end
    end

    assign ep.ep_datain  = datain_q;
    assign ep.ep_ready   = ready_q;
    assign ep.block_cnt  = blk_cnt_q;
    assign fill_level    = fill_q;
    assign overflow_cnt  = ovf_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_sim_to_pipe.sv
// Scoreboard bench for sim_to_pipe: expected words are queued when a frame is driven
// and compared as the pipe-out side pops them.
module tb_sim_to_pipe;

    logic         ti_clk = 1'b0;
    logic         reset_global = 1'b1;
    logic         reset_sim = 1'b0;
    logic         sim_clk = 1'b0;
    logic         enable = 1'b1;
    logic [127:0] ch_data = '0;
    logic [10:0]  fill_level;
    logic [15:0]  overflow_cnt;
    logic         underflow;

    sim_to_pipe_if ep_bus ();

    sim_to_pipe #(.NCH(4), .DEPTH_LOG2(10), .BLOCK_WORDS(256)) dut (
        .ti_clk       (ti_clk),
        .reset_global (reset_global),
        .reset_sim    (reset_sim),
        .sim_clk      (sim_clk),
        .enable       (enable),
        .ch_data      (ch_data),
        .ep           (ep_bus.slave),
        .fill_level   (fill_level),
        .overflow_cnt (overflow_cnt),
        .underflow    (underflow)
    );

    always #5 ti_clk = ~ti_clk;

    logic [15:0] sb [$];
    int          passed = 0;
    int          total = 0;
    int          model_words;
    int          budget;
    bit          pending;
    bit          stream_done;
    logic [15:0] exp_w;
    logic [127:0] frame;
    logic [15:0] t1_words [8];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] frm, input bit expect_store);
        @(negedge ti_clk);
        ch_data = frm;
        sim_clk = 1'b1;
        if (expect_store) begin
            for (int k = 0; k < 8; k++) sb.push_back(frm[16*k +: 16]);
        end
        repeat (6) @(negedge ti_clk);
        sim_clk = 1'b0;
        repeat (6) @(negedge ti_clk);
    endtask

    task automatic readWord(input string tag);
        logic [15:0] e;
        @(negedge ti_clk);
        ep_bus.ep_read = 1'b1;
        @(negedge ti_clk);
        ep_bus.ep_read = 1'b0;
        e = (sb.size() != 0) ? sb.pop_front() : 16'h0000;
        checkOutput(tag, {16'h0, ep_bus.ep_datain}, {16'h0, e});
    endtask

    function automatic logic [127:0] randFrame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ep_bus.ep_read = 1'b0;
        ep_bus.ep_blockstrobe = 1'b0;
        #2;
        checkOutput("reset_datain", {16'h0, ep_bus.ep_datain}, 32'h0);
        checkOutput("reset_fill", {21'h0, fill_level}, 32'h0);
        checkOutput("reset_ready", {31'h0, ep_bus.ep_ready}, 32'h0);
        checkOutput("reset_ovf", {16'h0, overflow_cnt}, 32'h0);
        checkOutput("reset_underflow", {31'h0, underflow}, 32'h0);
        repeat (3) @(negedge ti_clk);
        reset_global = 1'b0;
        repeat (3) @(negedge ti_clk);

        // Single known frame against literal word order
        t1_words = '{16'h0000, 16'h3F80, 16'h0000, 16'h4000,
                     16'h0000, 16'h0000, 16'h0000, 16'hC0A0};
        applyStimulus({32'hC0A00000, 32'h00000000, 32'h40000000, 32'h3F800000}, 1'b0);
        for (int k = 0; k < 8; k++) sb.push_back(t1_words[k]);
        repeat (2) @(negedge ti_clk);
        checkOutput("t1_fill8", {21'h0, fill_level}, 32'd8);
        checkOutput("t1_ready", {31'h0, ep_bus.ep_ready}, 32'h0);
        for (int k = 0; k < 8; k++) readWord("t1_word");
        checkOutput("t1_fill0", {21'h0, fill_level}, 32'd0);
        checkOutput("t1_underflow", {31'h0, underflow}, 32'h0);

        // Capture disabled
        enable = 1'b0;
        applyStimulus(randFrame(), 1'b0);
        repeat (2) @(negedge ti_clk);
        checkOutput("disabled_fill", {21'h0, fill_level}, 32'd0);
        enable = 1'b1;

        // Block ready at exactly 256 words
        model_words = 0;
        for (int f = 0; f < 32; f++) begin
            applyStimulus(randFrame(), 1'b1);
            repeat (2) @(negedge ti_clk);
            model_words += 8;
            checkOutput("blk_fill", {21'h0, fill_level}, model_words);
            checkOutput("blk_ready", {31'h0, ep_bus.ep_ready}, (model_words >= 256) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge ti_clk);
            ep_bus.ep_blockstrobe = 1'b1;
            @(negedge ti_clk);
            ep_bus.ep_blockstrobe = 1'b0;
        end
        checkOutput("blk_strobes", {16'h0, ep_bus.block_cnt}, 32'd3);
        for (int k = 0; k < 256; k++) begin
            readWord("blk_word");
            if (k == 0) checkOutput("blk_ready_fall", {31'h0, ep_bus.ep_ready}, 32'h0);
        end
        checkOutput("blk_fill0", {21'h0, fill_level}, 32'd0);

        // Overflow: 130 frames into 1024 words, no reads
        model_words = 0;
        for (int f = 0; f < 130; f++) begin
            if (model_words <= 1024 - 8) begin
                model_words += 8;
                applyStimulus(randFrame(), 1'b1);
            end else begin
                applyStimulus(randFrame(), 1'b0);
            end
        end
        repeat (4) @(negedge ti_clk);
        checkOutput("ovf_fill", {21'h0, fill_level}, 32'd1024);
        checkOutput("ovf_cnt", {16'h0, overflow_cnt}, 32'd2);
        checkOutput("ovf_ready", {31'h0, ep_bus.ep_ready}, 32'd1);
        for (int k = 0; k < 1024; k++) readWord("ovf_word");
        checkOutput("ovf_fill0", {21'h0, fill_level}, 32'd0);

        // Streaming with concurrent reads (push and pop in the same cycle)
        stream_done = 1'b0;
        pending = 1'b0;
        budget = 0;
        fork
            begin
                for (int f = 0; f < 12; f++) applyStimulus(randFrame(), 1'b1);
                stream_done = 1'b1;
            end
            begin
                while (!(stream_done && sb.size() == 0) && budget < 3000) begin
                    @(negedge ti_clk);
                    budget++;
                    if (pending) begin
                        exp_w = (sb.size() != 0) ? sb.pop_front() : 16'h0000;
                        checkOutput("stream_word", {16'h0, ep_bus.ep_datain}, {16'h0, exp_w});
                    end
                    ep_bus.ep_read = (fill_level != 0);
                    pending = ep_bus.ep_read;
                end
                ep_bus.ep_read = 1'b0;
            end
        join
        checkOutput("stream_drain", sb.size(), 32'd0);
        repeat (2) @(negedge ti_clk);
        checkOutput("stream_fill0", {21'h0, fill_level}, 32'd0);
        checkOutput("stream_underflow", {31'h0, underflow}, 32'h0);

        // Empty read, then flush in the middle of a frame write
        readWord("empty_datain");
        checkOutput("empty_underflow", {31'h0, underflow}, 32'd1);
        @(negedge ti_clk);
        ch_data = randFrame();
        sim_clk = 1'b1;
        repeat (5) @(negedge ti_clk);
        reset_sim = 1'b1;
        @(negedge ti_clk);
        reset_sim = 1'b0;
        checkOutput("flush_fill", {21'h0, fill_level}, 32'd0);
        checkOutput("flush_ovf", {16'h0, overflow_cnt}, 32'd0);
        checkOutput("flush_underflow", {31'h0, underflow}, 32'd0);
        repeat (8) @(negedge ti_clk);
        checkOutput("flush_idle", {21'h0, fill_level}, 32'd0);
        sim_clk = 1'b0;
        repeat (6) @(negedge ti_clk);
        sb.delete();
        applyStimulus(randFrame(), 1'b1);
        repeat (2) @(negedge ti_clk);
        checkOutput("post_flush_fill", {21'h0, fill_level}, 32'd8);
        for (int k = 0; k < 8; k++) readWord("post_flush_word");

        // Asynchronous global reset between edges, released while sim_clk is high
        applyStimulus(randFrame(), 1'b1);
        repeat (2) @(negedge ti_clk);
        readWord("pre_reset_word");
        @(negedge ti_clk);
        #2;
        reset_global = 1'b1;
        sim_clk = 1'b1;
        #1;
        checkOutput("greset_datain", {16'h0, ep_bus.ep_datain}, 32'h0);
        checkOutput("greset_fill", {21'h0, fill_level}, 32'h0);
        checkOutput("greset_ready", {31'h0, ep_bus.ep_ready}, 32'h0);
        checkOutput("greset_ovf", {16'h0, overflow_cnt}, 32'h0);
        checkOutput("greset_underflow", {31'h0, underflow}, 32'h0);
        sb.delete();
        @(negedge ti_clk);
        #3;
        reset_global = 1'b0;
        repeat (10) @(negedge ti_clk);
        checkOutput("no_spurious_rise", {21'h0, fill_level}, 32'd0);
        sim_clk = 1'b0;
        repeat (4) @(negedge ti_clk);
        frame = randFrame();
        applyStimulus(frame, 1'b1);
        repeat (2) @(negedge ti_clk);
        checkOutput("post_greset_fill", {21'h0, fill_level}, 32'd8);
        for (int k = 0; k < 8; k++) readWord("post_greset_word");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
